// File: rtl/hw_mutex_arbiter.sv
// Purpose : shares one Avalon hardware mutex between NUM_REQ hardware requesters,
//           round-robin arbitration plus the lock/verify/back-off/release protocol.
// Latency : req to grant is 3 edges on a free mutex; req drop to grant drop is 1 edge.
// Backpr. : none on the mutex port (zero-wait slave); requesters wait on a level req/grant.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   req[NUM_REQ]            per-requester level request, held for the critical section
//   grant[NUM_REQ]          registered one-hot (or zero) grant
//   busy                    arbiter not idle
//   hold_err / hold_err_clr sticky "grant held HOLD_MAX cycles" flag and its clear
//   m_*                     Avalon master towards the mutex slave (address 0 only)
module hw_mutex_arbiter #(
    parameter int          NUM_REQ    = 4,
    parameter logic [15:0] OWNER_BASE = 16'h0100,
    parameter logic [15:0] LOCK_VALUE = 16'h0001,
    parameter int          BACKOFF    = 16,
    parameter int          HOLD_MAX   = 4096
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic               busy,
    output logic               hold_err,
    input  logic               hold_err_clr,
    output logic               m_address,
    output logic               m_chipselect,
    output logic               m_write,
    output logic               m_read,
    output logic [31:0]        m_writedata,
    input  logic [31:0]        m_readdata
);

    localparam int SW = (NUM_REQ > 1)  ? $clog2(NUM_REQ)      : 1;
    localparam int BW = (BACKOFF > 1)  ? $clog2(BACKOFF)      : 1;
    localparam int HW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRY_WR,
        ST_TRY_RD,
        ST_BACKOFF,
        ST_GRANTED,
        ST_REL_WR
    } state_t;

    state_t             r_state;
    logic [SW-1:0]      r_sel;
    logic [SW-1:0]      r_ptr;
    logic [BW-1:0]      r_bo_cnt;
    logic [HW-1:0]      r_hold_cnt;
    logic [NUM_REQ-1:0] r_grant;
    logic               r_busy;
    logic               r_hold_err;
    logic               r_cs;
    logic               r_wr;
    logic               r_rd;
    logic [31:0]        r_wdat;

    state_t             w_state_nxt;
    logic [SW-1:0]      w_sel_nxt;
    logic [SW-1:0]      w_pick;
    logic               w_any;
    logic [NUM_REQ-1:0] w_rot;
    logic [SW:0]        w_off;
    logic [SW:0]        w_sum;
    logic [15:0]        w_owner_cur;
    logic [15:0]        w_owner_nxt;
    logic               w_acquired;
    logic               w_req_sel;
    logic [SW-1:0]      w_ptr_nxt;
    logic               w_hold_hit;

    assign w_owner_cur = OWNER_BASE + 16'(r_sel);
    assign w_owner_nxt = OWNER_BASE + 16'(w_sel_nxt);
    assign w_req_sel   = req[r_sel];
    // Ownership is proven only by reading back our own owner ID and lock value;
    // the slave silently ignores a write while someone else holds it.
    assign w_acquired  = (m_readdata == {w_owner_cur, LOCK_VALUE});
    assign w_ptr_nxt   = (r_sel == SW'(NUM_REQ - 1)) ? '0 : r_sel + SW'(1);
    assign w_hold_hit  = (HOLD_MAX != 0) && (r_state == ST_GRANTED) &&
                         (r_hold_cnt == HW'(HOLD_MAX - 1));

    // Round-robin pick: rotate req so bit 0 is the requester at ptr, take the
    // lowest set bit, then rotate the offset back with wrap.
    always_comb begin
        w_any = |req;
        w_rot = NUM_REQ'({req, req} >> r_ptr);
        w_off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = (SW+1)'(k);
            end
        end
        w_sum  = {1'b0, r_ptr} + w_off;
        w_pick = (w_sum >= (SW+1)'(NUM_REQ)) ? SW'(w_sum - (SW+1)'(NUM_REQ)) : SW'(w_sum);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nxt = ST_TRY_WR;
                    w_sel_nxt   = w_pick;
                end
            end
            ST_TRY_WR: w_state_nxt = ST_TRY_RD;
            ST_TRY_RD: begin
                if (!w_acquired) begin
                    w_state_nxt = ST_BACKOFF;
                end else if (w_req_sel) begin
                    w_state_nxt = ST_GRANTED;
                end else begin
                    // Requester withdrew mid-acquire: hand the lock straight back.
                    w_state_nxt = ST_REL_WR;
                end
            end
            ST_BACKOFF: begin
                if (!w_req_sel || (r_bo_cnt == BW'(BACKOFF - 1))) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_GRANTED: begin
                if (!w_req_sel) begin
                    w_state_nxt = ST_REL_WR;
                end
            end
            ST_REL_WR: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet
    // line up with the state they belong to.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_sel      <= '0;
            r_ptr      <= '0;
            r_bo_cnt   <= '0;
            r_hold_cnt <= '0;
            r_grant    <= '0;
            r_busy     <= 1'b0;
            r_hold_err <= 1'b0;
            r_cs       <= 1'b0;
            r_wr       <= 1'b0;
            r_rd       <= 1'b0;
            r_wdat     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_cs    <= (w_state_nxt == ST_TRY_WR) || (w_state_nxt == ST_TRY_RD) ||
                       (w_state_nxt == ST_REL_WR);
            r_wr    <= (w_state_nxt == ST_TRY_WR) || (w_state_nxt == ST_REL_WR);
            r_rd    <= (w_state_nxt == ST_TRY_RD);
            r_grant <= (w_state_nxt == ST_GRANTED) ? (NUM_REQ'(1) << w_sel_nxt) : '0;

            case (w_state_nxt)
                ST_TRY_WR: r_wdat <= {w_owner_nxt, LOCK_VALUE};
                ST_REL_WR: r_wdat <= {w_owner_nxt, 16'h0000};
                default:   r_wdat <= '0;
            endcase

            // Backoff count restarts on every entry; ptr is left alone so a
            // blocked requester keeps its turn.
            if (r_state == ST_BACKOFF) begin
                r_bo_cnt <= r_bo_cnt + BW'(1);
            end else begin
                r_bo_cnt <= '0;
            end

            if (r_state == ST_REL_WR) begin
                r_ptr      <= w_ptr_nxt;
                r_hold_cnt <= '0;
            end else if ((HOLD_MAX != 0) && (r_state == ST_GRANTED) &&
                         (r_hold_cnt != HW'(HOLD_MAX))) begin
                r_hold_cnt <= r_hold_cnt + HW'(1);
            end

            // A set event beats a simultaneous clear.
            if (w_hold_hit) begin
                r_hold_err <= 1'b1;
            end else if (hold_err_clr) begin
                r_hold_err <= 1'b0;
            end
        end
    end

    assign grant        = r_grant;
    assign busy         = r_busy;
    assign hold_err     = r_hold_err;
    assign m_address    = 1'b0;
    assign m_chipselect = r_cs;
    assign m_write      = r_wr;
    assign m_read       = r_rd;
    assign m_writedata  = r_wdat;

endmodule

// File: tb/tb_hw_mutex_arbiter.sv
module tb_hw_mutex_arbiter;

    localparam int N     = 4;
    localparam int K_WR  = 0;
    localparam int K_RD  = 1;
    localparam int K_GNT = 2;
    localparam int K_BAD = 3;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   grant;
    logic           busy;
    logic           hold_err;
    logic           hold_err_clr = 1'b0;
    logic           m_address;
    logic           m_chipselect;
    logic           m_write;
    logic           m_read;
    logic [31:0]    m_writedata;
    logic [31:0]    m_readdata;

    logic           cpu_wr = 1'b0;
    logic [31:0]    cpu_wdata = '0;
    logic [31:0]    mtx;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int mark = 0;
    int last_ev = 0;

    typedef struct {
        int          kind;
        logic [31:0] dat;
        int          gap;
    } ev_t;
    ev_t exp_q[$];

    hw_mutex_arbiter #(
        .NUM_REQ   (N),
        .OWNER_BASE(16'h0100),
        .LOCK_VALUE(16'h0001),
        .BACKOFF   (16),
        .HOLD_MAX  (8)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
        .grant       (grant),
        .busy        (busy),
        .hold_err    (hold_err),
        .hold_err_clr(hold_err_clr),
        .m_address   (m_address),
        .m_chipselect(m_chipselect),
        .m_write     (m_write),
        .m_read      (m_read),
        .m_writedata (m_writedata),
        .m_readdata  (m_readdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Avalon mutex model: a write lands if the mutex is free or the writer owns it.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mtx <= '0;
        end else if (m_chipselect && m_write) begin
            if (mtx[15:0] == 16'h0 || mtx[31:16] == m_writedata[31:16]) mtx <= m_writedata;
        end else if (cpu_wr) begin
            if (mtx[15:0] == 16'h0 || mtx[31:16] == cpu_wdata[31:16]) mtx <= cpu_wdata;
        end
    end
    assign m_readdata = mtx;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [31:0] dat, input int gap);
        ev_t e;
        e.kind = kind;
        e.dat  = dat;
        e.gap  = gap;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int kind, input logic [31:0] dat);
        ev_t e;
        int  ref_c;
        int  g;
        ref_c   = (last_ev > mark) ? last_ev : mark;
        g       = cyc - ref_c;
        last_ev = cyc;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event: got kind=%0d dat=0x%08h gap=%0d, want none", kind, dat, g);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.dat !== dat || (e.gap >= 0 && e.gap != g)) begin
                bad++;
                $display("FAIL bus_event: got kind=%0d dat=0x%08h gap=%0d, want kind=%0d dat=0x%08h gap=%0d",
                         kind, dat, g, e.kind, e.dat, e.gap);
            end
        end
    endtask

    // Monitor: every grant change and every mutex bus cycle is one observed event.
    initial begin : monitor
        logic [N-1:0] prev;
        prev = '0;
        @(posedge reset_n);
        forever begin
            @(negedge clk);
            if (grant !== prev) begin
                observe(K_GNT, 32'(grant));
                prev = grant;
            end
            if (m_chipselect === 1'b1) begin
                if (m_write)     observe(K_WR, m_writedata);
                else if (m_read) observe(K_RD, 32'h0);
                else             observe(K_BAD, 32'h0);
            end
        end
    end

    task automatic wait_grant(input int idx);
        logic [N-1:0] msk;
        int n;
        msk = N'(1) << idx;
        n = 0;
        while ((grant & msk) == '0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("grant%0d_seen", idx), 32'(grant & msk), 32'(msk));
    endtask

    function automatic logic [31:0] wd(input int idx, input logic [15:0] val);
        return {16'(16'h0100 + idx), val};
    endfunction

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [N-1:0] msk;
        int idx;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_hold_err", 32'(hold_err), 32'h0);
        chk("rst_mbus", {28'h0, m_address, m_chipselect, m_write, m_read}, 32'h0);
        chk("rst_wdata", m_writedata, 32'h0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", 32'(busy), 32'h0);

        // Round-robin: all request, each holds 10 cycles then re-requests
        mark = cyc;
        req  = '1;
        for (int g = 0; g < 5; g++) begin
            idx = g % N;
            msk = N'(1) << idx;
            push(K_WR, wd(idx, 16'h0001), (g == 0) ? 1 : 2);
            push(K_RD, 32'h0, 1);
            push(K_GNT, 32'(msk), 1);
            wait_grant(idx);
            repeat (10) @(negedge clk);
            push(K_GNT, 32'h0, 11);
            push(K_WR, wd(idx, 16'h0000), 0);
            if (g == 4) req = '0;
            else        req = req & ~msk;
            @(negedge clk);
            if (g != 4) req = req | msk;
        end
        repeat (3) @(negedge clk);
        chk("rr_hold_err_set", 32'(hold_err), 32'h1);

        // Single requester, free mutex
        mark = cyc;
        req  = 4'b0001;
        push(K_WR, 32'h0100_0001, 1);
        push(K_RD, 32'h0, 1);
        push(K_GNT, 32'h1, 1);
        wait_grant(0);
        chk("t1_busy_granted", 32'(busy), 32'h1);
        repeat (4) @(negedge clk);
        push(K_GNT, 32'h0, 5);
        push(K_WR, 32'h0100_0000, 0);
        req = '0;
        @(negedge clk);
        chk("t1_grant_low", 32'(grant), 32'h0);
        chk("t1_busy_rel", 32'(busy), 32'h1);
        @(negedge clk);
        chk("t1_busy_idle", 32'(busy), 32'h0);
        chk("t1_mutex_free", 32'(mtx[15:0]), 32'h0);

        // CPU holds the mutex: attempts back off until it is released
        cpu_wdata = 32'h0005_0001;
        cpu_wr    = 1'b1;
        @(negedge clk);
        cpu_wr = 1'b0;
        chk("t3_cpu_lock", mtx, 32'h0005_0001);
        mark = cyc;
        req  = 4'b0100;
        push(K_WR, 32'h0102_0001, 1);
        push(K_RD, 32'h0, 1);
        push(K_WR, 32'h0102_0001, 18);
        push(K_RD, 32'h0, 1);
        push(K_WR, 32'h0102_0001, 18);
        push(K_RD, 32'h0, 1);
        repeat (30) @(negedge clk);
        chk("t3_no_grant", 32'(grant), 32'h0);
        chk("t3_busy_backoff", 32'(busy), 32'h1);
        repeat (15) @(negedge clk);
        cpu_wdata = 32'h0005_0000;
        cpu_wr    = 1'b1;
        @(negedge clk);
        cpu_wr = 1'b0;
        chk("t3_cpu_unlock", mtx, 32'h0005_0000);
        push(K_WR, 32'h0102_0001, 18);
        push(K_RD, 32'h0, 1);
        push(K_GNT, 32'h4, 1);
        wait_grant(2);
        repeat (3) @(negedge clk);
        push(K_GNT, 32'h0, 4);
        push(K_WR, 32'h0102_0000, 0);
        req = '0;
        repeat (3) @(negedge clk);

        // Withdraw during acquire: lock is released without a grant
        mark = cyc;
        req  = 4'b0010;
        push(K_WR, 32'h0101_0001, 1);
        push(K_RD, 32'h0, 1);
        push(K_WR, 32'h0101_0000, 1);
        repeat (2) @(negedge clk);
        req = '0;
        repeat (4) @(negedge clk);
        chk("t4_no_grant", 32'(grant), 32'h0);
        chk("t4_mutex_free", 32'(mtx[15:0]), 32'h0);
        chk("t4_busy_idle", 32'(busy), 32'h0);

        // Hold timeout
        hold_err_clr = 1'b1;
        @(negedge clk);
        hold_err_clr = 1'b0;
        chk("t5_clr_idle", 32'(hold_err), 32'h0);
        mark = cyc;
        req  = 4'b0001;
        push(K_WR, 32'h0100_0001, 1);
        push(K_RD, 32'h0, 1);
        push(K_GNT, 32'h1, 1);
        wait_grant(0);
        repeat (7) @(negedge clk);
        chk("t5_hold_err_pre", 32'(hold_err), 32'h0);
        @(negedge clk);
        chk("t5_hold_err_set", 32'(hold_err), 32'h1);
        chk("t5_grant_kept", 32'(grant), 32'h1);
        repeat (3) @(negedge clk);
        hold_err_clr = 1'b1;
        @(negedge clk);
        hold_err_clr = 1'b0;
        chk("t5_hold_err_clr", 32'(hold_err), 32'h0);
        chk("t5_grant_after_clr", 32'(grant), 32'h1);
        repeat (8) @(negedge clk);
        chk("t5_hold_err_stays", 32'(hold_err), 32'h0);
        push(K_GNT, 32'h0, 21);
        push(K_WR, 32'h0100_0000, 0);
        req = '0;
        repeat (3) @(negedge clk);

        // Asynchronous reset while granted
        mark = cyc;
        req  = 4'b1000;
        push(K_WR, 32'h0103_0001, 1);
        push(K_RD, 32'h0, 1);
        push(K_GNT, 32'h8, 1);
        wait_grant(3);
        repeat (2) @(negedge clk);
        push(K_GNT, 32'h0, -1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_grant_async", 32'(grant), 32'h0);
        chk("t6_mbus_async", {28'h0, m_address, m_chipselect, m_write, m_read}, 32'h0);
        chk("t6_busy_async", 32'(busy), 32'h0);
        chk("t6_mutex_reset", mtx, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        mark = cyc;
        push(K_WR, 32'h0103_0001, 1);
        push(K_RD, 32'h0, 1);
        push(K_GNT, 32'h8, 1);
        wait_grant(3);
        repeat (2) @(negedge clk);
        push(K_GNT, 32'h0, 3);
        push(K_WR, 32'h0103_0000, 0);
        req = '0;
        repeat (4) @(negedge clk);

        chk("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
